// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state type and lane helper
// for the load/store unit and its load-alignment sub-module.
package lsu_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } lsu_state_t;

    // Byte lanes for an access at offset 0; reserved size gives none.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_WORD: lane_mask = 4'b1111;
            SIZE_HALF: lane_mask = 4'b0011;
            SIZE_BYTE: lane_mask = 4'b0001;
            default:   lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts {beat1, beat0} down by the byte offset,
// truncates to the access size and zero/sign extends.
// Ports: data (64b two-beat read), off (byte offset), size, sign,
//        result (32b extended load value).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [31:0] lo;

    assign lo = 32'(data >> {off, 3'b000});

    always_comb begin
        result = '0;
        case (size)
            SIZE_WORD: result = lo;
            SIZE_HALF: result = {{16{sign & lo[15]}}, lo[15:0]};
            SIZE_BYTE: result = {{24{sign & lo[7]}}, lo[7:0]};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-side load/store initiator on a word-aligned,
// byte-enabled memory bus; splits word-crossing accesses in two beats.
// Core side: clk, rst, req_valid/req_ready, MemWrite, LoadSign, size,
//   ALUResult, WriteData -> resp_valid, resp_err, Result.
// Bus side: mem_req/we/addr/be/wdata -> mem_gnt, mem_rvalid, mem_rdata.
// Build option: LSU_MISALIGN_TRAP_EN rejects crossing accesses
//   with resp_err instead of splitting them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             MemWrite,
    input  logic             LoadSign,
    input  logic [1:0]       size,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] WriteData,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] Result,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t         state, state_n;

    logic               q_we, q_sign, q_beat, q_err;
    logic [1:0]         q_size, q_off;
    logic [WIDTH-1:0]   q_base;
    logic [7:0]         q_mask;
    logic [2*WIDTH-1:0] q_wdata, q_rdata;

    logic               accept, reject, more, is_req;
    logic [7:0]         mask8;
    logic [2*WIDTH-1:0] rd_cat;
    logic [WIDTH-1:0]   ld_val;

    assign accept = req_valid & (state == IDLE);
    assign mask8  = 8'({4'b0000, lane_mask(size)} << ALUResult[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign reject = (size == SIZE_RSVD) | (|mask8[7:4]);
    assign more   = 1'b0;
`else
    assign reject = (size == SIZE_RSVD);
    assign more   = ~q_beat & (|q_mask[7:4]);
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = reject ? DONE : REQ;
            REQ:  if (mem_gnt) state_n = RSP;
            RSP:  if (mem_rvalid) state_n = more ? REQ : DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The last beat is still on mem_rdata when Result is loaded.
    assign rd_cat = q_beat ? {mem_rdata, q_rdata[WIDTH-1:0]}
                           : {q_rdata[2*WIDTH-1:WIDTH], mem_rdata};

    lsu_load_align u_align (
        .data   (rd_cat),
        .off    (q_off),
        .size   (q_size),
        .sign   (q_sign),
        .result (ld_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_we    <= 1'b0;
            q_sign  <= 1'b0;
            q_beat  <= 1'b0;
            q_err   <= 1'b0;
            q_size  <= '0;
            q_off   <= '0;
            q_base  <= '0;
            q_mask  <= '0;
            q_wdata <= '0;
            q_rdata <= '0;
            Result  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                q_we    <= MemWrite;
                q_sign  <= LoadSign;
                q_size  <= size;
                q_off   <= ALUResult[1:0];
                q_base  <= {ALUResult[WIDTH-1:2], 2'b00};
                q_mask  <= mask8;
                q_wdata <= {{WIDTH{1'b0}}, WriteData}
                           << {ALUResult[1:0], 3'b000};
                q_beat  <= 1'b0;
                q_err   <= reject;
            end
            if (state == RSP && mem_rvalid) begin
                q_rdata <= rd_cat;
                if (more) q_beat <= 1'b1;
            end
            if (state_n == DONE && state != DONE)
                Result <= (state == RSP && !q_we) ? ld_val : '0;
        end
    end

    assign is_req     = (state == REQ);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) & q_err;
    assign mem_req    = is_req;
    assign mem_we     = is_req & q_we;
    assign mem_addr   = is_req ? q_base + {{(WIDTH-3){1'b0}}, q_beat, 2'b00}
                               : '0;
    assign mem_be     = !is_req ? 4'b0000
                      : (q_beat ? q_mask[7:4] : q_mask[3:0]);
    assign mem_wdata  = !is_req ? '0
                      : (q_beat ? q_wdata[2*WIDTH-1:WIDTH]
                                : q_wdata[WIDTH-1:0]);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit against a
// behavioural memory with programmable grant/response delays.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, req_valid, MemWrite, LoadSign;
    logic [1:0]  size;
    logic [31:0] ALUResult, WriteData;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] Result;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .MemWrite(MemWrite), .LoadSign(LoadSign), .size(size),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .resp_valid(resp_valid), .resp_err(resp_err), .Result(Result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: decides gnt/rvalid on the falling edge.
    logic [31:0] mem [0:63];
    int gnt_delay = 0;
    int rv_delay  = 1;
    int stray_req = 0;
    int beat_n    = 0;
    logic [31:0] log_addr  [0:15];
    logic [31:0] log_wdata [0:15];
    logic [3:0]  log_be    [0:15];
    logic        log_we    [0:15];

    initial begin
        int wait_cnt;
        int rv_cnt;
        int stray_done;
        wait_cnt = 0; rv_cnt = 0; stray_done = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) mem_rvalid = 1'b1;
            end
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                mem_rvalid = 1'b1;
            end
            if (mem_req) begin
                if (wait_cnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    wait_cnt = 0;
                    rv_cnt = rv_delay;
                    log_addr[beat_n % 16]  = mem_addr;
                    log_wdata[beat_n % 16] = mem_wdata;
                    log_be[beat_n % 16]    = mem_be;
                    log_we[beat_n % 16]    = mem_we;
                    beat_n++;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b])
                                mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        mem_rdata = mem[mem_addr[7:2]];
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic sg,
                         input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; MemWrite = we; LoadSign = sg;
        size = sz; ALUResult = a; WriteData = wd;
        @(posedge clk);
        #1;
        // Scramble inputs: the unit must use the latched copy.
        req_valid = 1'b0; MemWrite = ~we; LoadSign = ~sg;
        size = ~sz; ALUResult = ~a; WriteData = ~wd;
    endtask

    task automatic run(input int start, output int lat,
                       output logic err, output logic [31:0] res);
        lat = 0; err = 1'b0; res = '0;
        for (int c = start + 1; c <= start + 30; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; err = resp_err; res = Result;
                break;
            end
        end
        n_cmp++;
        assert (lat != 0) else begin
            n_bad++;
            $error("FAIL resp_timeout: observed none expected resp_valid");
        end
    endtask

    initial begin
        int lat, b0, cnt;
        logic err;
        logic [31:0] res;

        rst = 1'b1; req_valid = 1'b0; MemWrite = 1'b0; LoadSign = 1'b0;
        size = 2'b00; ALUResult = '0; WriteData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
        chk("rst_result", Result, 32'd0);
        rst = 1'b0;

        // sw 0xDEADBEEF @0x10
        b0 = beat_n;
        issue(1'b1, 1'b0, 2'b00, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_req", {30'b0, mem_req, mem_we}, 32'd3);
        chk("sw_addr", mem_addr, 32'h10);
        chk("sw_be", {28'b0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_busy", {31'b0, req_ready}, 32'd0);
        run(1, lat, err, res);
        chk("sw_lat", lat, 32'd3);
        chk("sw_result", res, 32'd0);
        chk("sw_beats", beat_n - b0, 32'd1);
        @(negedge clk);
        chk("sw_ready_t4", {31'b0, req_ready}, 32'd1);

        // sb 0xA5 @0x13
        b0 = beat_n;
        issue(1'b1, 1'b0, 2'b10, 32'h13, 32'h000000A5);
        run(0, lat, err, res);
        chk("sb_beats", beat_n - b0, 32'd1);
        chk("sb_addr", log_addr[b0 % 16], 32'h10);
        chk("sb_be", {28'b0, log_be[b0 % 16]}, 32'h8);
        chk("sb_wdata", log_wdata[b0 % 16], 32'hA5000000);

        issue(1'b0, 1'b1, 2'b10, 32'h13, 32'h0);
        run(0, lat, err, res);
        chk("lb_result", res, 32'hFFFFFFA5);
        chk("lb_lat", lat, 32'd3);
        issue(1'b0, 1'b0, 2'b10, 32'h13, 32'h0);
        run(0, lat, err, res);
        chk("lbu_result", res, 32'h000000A5);

        // sh 0x8001 @0x23 crosses into the next word
        b0 = beat_n;
        issue(1'b1, 1'b0, 2'b01, 32'h23, 32'h00008001);
        run(0, lat, err, res);
        chk("sh_beats", beat_n - b0, 32'd2);
        chk("sh_lat", lat, 32'd5);
        chk("sh_b0_addr", log_addr[b0 % 16], 32'h20);
        chk("sh_b0_be", {28'b0, log_be[b0 % 16]}, 32'h8);
        chk("sh_b0_wdata", log_wdata[b0 % 16], 32'h01000000);
        chk("sh_b1_addr", log_addr[(b0 + 1) % 16], 32'h24);
        chk("sh_b1_be", {28'b0, log_be[(b0 + 1) % 16]}, 32'h1);
        chk("sh_b1_wdata", log_wdata[(b0 + 1) % 16], 32'h00000080);
        chk("sh_b1_we", {31'b0, log_we[(b0 + 1) % 16]}, 32'd1);
        issue(1'b0, 1'b1, 2'b01, 32'h23, 32'h0);
        run(0, lat, err, res);
        chk("lh_result", res, 32'hFFFF8001);

        // lw @0x06 with a 3-cycle grant stall per beat
        issue(1'b1, 1'b0, 2'b00, 32'h04, 32'h44332211);
        run(0, lat, err, res);
        issue(1'b1, 1'b0, 2'b00, 32'h08, 32'h88776655);
        run(0, lat, err, res);
        gnt_delay = 3;
        issue(1'b0, 1'b0, 2'b00, 32'h06, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) stray_req++;
            chk($sformatf("lw6_req_c%0d", k), {31'b0, mem_req}, 32'd1);
            chk($sformatf("lw6_addr_c%0d", k), mem_addr, 32'h04);
            chk($sformatf("lw6_be_c%0d", k), {28'b0, mem_be}, 32'hC);
        end
        run(4, lat, err, res);
        chk("lw6_lat", lat, 32'd11);
        chk("lw6_result", res, 32'h66554433);
        gnt_delay = 0;

        // Reserved size: immediate error, no bus traffic
        b0 = beat_n;
        issue(1'b0, 1'b0, 2'b11, 32'h40, 32'h0);
        run(0, lat, err, res);
        chk("rsvd_err", {31'b0, err}, 32'd1);
        chk("rsvd_beats", beat_n - b0, 32'd0);
        chk("rsvd_result", res, 32'd0);
        chk("rsvd_lat_le2", {31'b0, (lat >= 1 && lat <= 2)}, 32'd1);

        // lw @0x02 crosses a word boundary
        b0 = beat_n;
        issue(1'b0, 1'b0, 2'b00, 32'h02, 32'h0);
        run(0, lat, err, res);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_err", {31'b0, err}, 32'd1);
        chk("mis_beats", beat_n - b0, 32'd0);
        chk("mis_result", res, 32'd0);
`else
        chk("mis_err", {31'b0, err}, 32'd0);
        chk("mis_beats", beat_n - b0, 32'd2);
        chk("mis_b1_be", {28'b0, log_be[(b0 + 1) % 16]}, 32'h3);
        chk("mis_result", res, 32'h22110000);
`endif

        // Reset while waiting for rvalid, then a late rvalid
        rv_delay = 3;
        issue(1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_req", {31'b0, mem_req}, 32'd0);
        chk("rstmid_resp", {31'b0, resp_valid}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid || mem_req) cnt++;
            if (k == 0)
                chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
        end
        chk("rstmid_quiet", cnt, 32'd0);
        rv_delay = 1;

        issue(1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
        run(0, lat, err, res);
        chk("post_rst_lw", res, 32'hA5ADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
